// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and decode-control types for the ID/EX pipeline register
// Purpose: default field widths, the packed decode-control struct and the bubble constant.
// Ports: none (package).
package pipe_pkg;

   localparam int DATA_W  = 32;
   localparam int RN_W    = 5;
   localparam int ALUC_W  = 5;
   localparam int DEPEN_W = 2;

   typedef struct packed {
      logic              wreg;
      logic              m2reg;
      logic              wmem;
      logic              aluimm;
      logic              shift;
      logic              jal;
      logic              j;
      logic              beq;
      logic              bne;
      logic [ALUC_W-1:0] aluc;
   } de_ctl_t;

   localparam de_ctl_t DE_BUBBLE = '0;

endpackage

// File: rtl/pipe_de_ctl_reg_if.sv
// rtl/pipe_de_ctl_reg_if.sv - one pipeline-stage view of an instruction slot
// Purpose: bundles valid, decode control and data fields of one stage.
// Ports: master drives all fields, slave receives all fields.
interface pipe_de_ctl_reg_if #(
   parameter int DATA_W  = pipe_pkg::DATA_W,
   parameter int RN_W    = pipe_pkg::RN_W,
   parameter int DEPEN_W = pipe_pkg::DEPEN_W
);
   import pipe_pkg::*;

   logic               valid;
   de_ctl_t            ctl;
   logic [DATA_W-1:0]  a;
   logic [DATA_W-1:0]  b;
   logic [DATA_W-1:0]  imm;
   logic [DATA_W-1:0]  pc4;
   logic [RN_W-1:0]    rn;
   logic [DEPEN_W-1:0] adepen;
   logic [DEPEN_W-1:0] bdepen;

   modport master (output valid, ctl, a, b, imm, pc4, rn, adepen, bdepen);
   modport slave  (input  valid, ctl, a, b, imm, pc4, rn, adepen, bdepen);

endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter
// Purpose: counts cycles with i_inc high, sticks at all-ones, cleared by i_clr.
// Ports: i_clk clock, i_clr sync active-high clear, i_inc count enable,
//        o_count current count.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);
   import pipe_pkg::*;

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_de_ctl_reg.sv
// rtl/pipe_de_ctl_reg.sv - decode->execute pipeline register with stall, flush and event counters
// Purpose: registers the decode slot into the execute slot; holds on stall, loads a
//          bubble on flush, and counts stall cycles and inserted bubbles.
// Ports: i_clk clock, i_clr sync active-high reset, i_stall hold, i_flush bubble,
//        i_d decode-side slot (slave), o_e execute-side slot (master),
//        o_stall_cnt / o_bubble_cnt saturating event counts.
module pipe_de_ctl_reg #(
   parameter int DATA_W  = pipe_pkg::DATA_W,
   parameter int RN_W    = pipe_pkg::RN_W,
   parameter int DEPEN_W = pipe_pkg::DEPEN_W,
   parameter int CNT_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_clr,
   input  logic              i_stall,
   input  logic              i_flush,
   pipe_de_ctl_reg_if.slave  i_d,
   pipe_de_ctl_reg_if.master o_e,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_bubble_cnt
);
   import pipe_pkg::*;

   typedef struct packed {
      logic               valid;
      de_ctl_t            ctl;
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
      logic [DATA_W-1:0]  imm;
      logic [DATA_W-1:0]  pc4;
      logic [RN_W-1:0]    rn;
      logic [DEPEN_W-1:0] adepen;
      logic [DEPEN_W-1:0] bdepen;
   } pay_t;

   pay_t w_load;
   pay_t r_pay;

   // An invalid slot is loaded verbatim except for the bits that could commit
   // state or redirect the PC, so it can never have a side effect.
   always_comb begin
      w_load        = '{valid: i_d.valid, ctl: i_d.ctl, a: i_d.a, b: i_d.b,
                        imm: i_d.imm, pc4: i_d.pc4, rn: i_d.rn,
                        adepen: i_d.adepen, bdepen: i_d.bdepen};
      if (!i_d.valid) begin
         w_load.ctl.wreg = 1'b0;
         w_load.ctl.wmem = 1'b0;
         w_load.ctl.jal  = 1'b0;
         w_load.ctl.j    = 1'b0;
         w_load.ctl.beq  = 1'b0;
         w_load.ctl.bne  = 1'b0;
      end
   end

   // Priority: clear, then bubble (flush beats stall), then hold, then load.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_pay <= '0;
      end else if (i_flush) begin
         r_pay     <= '0;
         r_pay.ctl <= DE_BUBBLE;
      end else if (!i_stall) begin
         r_pay <= w_load;
      end
   end

   assign o_e.valid  = r_pay.valid;
   assign o_e.ctl    = r_pay.ctl;
   assign o_e.a      = r_pay.a;
   assign o_e.b      = r_pay.b;
   assign o_e.imm    = r_pay.imm;
   assign o_e.pc4    = r_pay.pc4;
   assign o_e.rn     = r_pay.rn;
   assign o_e.adepen = r_pay.adepen;
   assign o_e.bdepen = r_pay.bdepen;

   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_clr   (i_clr),
      .i_inc   (i_stall),
      .o_count (o_stall_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .i_clk   (i_clk),
      .i_clr   (i_clr),
      .i_inc   (i_flush),
      .o_count (o_bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_de_ctl_reg.sv
// tb/tb_pipe_de_ctl_reg.sv - self-checking bench for pipe_de_ctl_reg
module tb_pipe_de_ctl_reg;
   import pipe_pkg::*;

   typedef struct packed {
      logic        valid;
      de_ctl_t     ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rn;
      logic [1:0]  adepen;
      logic [1:0]  bdepen;
   } st_t;

   typedef struct {
      logic        clr, stall, flush, dvalid, dwreg, dwmem, dbeq;
      logic [31:0] da;
      logic [4:0]  drn;
      logic        xv, xw, xm, xb;
      logic [31:0] xa;
      logic [4:0]  xr;
      int          xsc, xbc;
   } vec_t;

   logic        clk = 1'b0;
   logic        clr, stall, flush;
   logic [15:0] stall_cnt, bubble_cnt;
   logic [3:0]  stall_cnt4, bubble_cnt4;
   st_t         din, act, act4, m;
   int          msc, mbc, msc4, mbc4;
   int          n_tests, n_fail;

   pipe_de_ctl_reg_if d_if ();
   pipe_de_ctl_reg_if e_if ();
   pipe_de_ctl_reg_if e4_if ();

   always #5 clk = ~clk;

   assign {d_if.valid, d_if.ctl, d_if.a, d_if.b, d_if.imm, d_if.pc4,
           d_if.rn, d_if.adepen, d_if.bdepen} = din;
   assign act  = {e_if.valid, e_if.ctl, e_if.a, e_if.b, e_if.imm, e_if.pc4,
                  e_if.rn, e_if.adepen, e_if.bdepen};
   assign act4 = {e4_if.valid, e4_if.ctl, e4_if.a, e4_if.b, e4_if.imm, e4_if.pc4,
                  e4_if.rn, e4_if.adepen, e4_if.bdepen};

   pipe_de_ctl_reg dut (
      .i_clk(clk), .i_clr(clr), .i_stall(stall), .i_flush(flush),
      .i_d(d_if), .o_e(e_if),
      .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
   );

   pipe_de_ctl_reg #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_clr(clr), .i_stall(stall), .i_flush(flush),
      .i_d(d_if), .o_e(e4_if),
      .o_stall_cnt(stall_cnt4), .o_bubble_cnt(bubble_cnt4)
   );

   task automatic chk(input string nm, input logic [255:0] a_v, input logic [255:0] e_v);
      n_tests++;
      if (a_v !== e_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a_v, e_v);
      end
   endtask

   function automatic st_t rand_st();
      st_t s;
      s.valid  = 1'($urandom);
      s.ctl    = de_ctl_t'(14'($urandom));
      s.a      = $urandom;
      s.b      = $urandom;
      s.imm    = $urandom;
      s.pc4    = $urandom;
      s.rn     = 5'($urandom);
      s.adepen = 2'($urandom);
      s.bdepen = 2'($urandom);
      return s;
   endfunction

   function automatic int sat_inc(input int v, input int lim);
      return (v >= lim) ? lim : v + 1;
   endfunction

   // Reference behaviour of one clock edge, evaluated from the inputs in front of it.
   task automatic model_edge();
      if (clr) begin
         m = '0; msc = 0; mbc = 0; msc4 = 0; mbc4 = 0;
      end else begin
         if (stall) begin
            msc  = sat_inc(msc, 65535);
            msc4 = sat_inc(msc4, 15);
         end
         if (flush) begin
            mbc  = sat_inc(mbc, 65535);
            mbc4 = sat_inc(mbc4, 15);
            m    = '0;
         end else if (!stall) begin
            m = din;
            if (!din.valid) begin
               m.ctl.wreg = 1'b0; m.ctl.wmem = 1'b0; m.ctl.jal = 1'b0;
               m.ctl.j    = 1'b0; m.ctl.beq  = 1'b0; m.ctl.bne = 1'b0;
            end
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   vec_t vt[14];

   initial begin
      n_tests = 0; n_fail = 0;
      m = '0; msc = 0; mbc = 0; msc4 = 0; mbc4 = 0;
      clr = 1'b1; stall = 1'b0; flush = 1'b0; din = '0;

      //      clr st fl  dv dw dm db  da            rn    xv xw xm xb  xa            xr    sc bc
      vt[0]  = '{1, 0, 0,  1, 1, 1, 1, 32'h0BAD0001, 5'd4,  0, 0, 0, 0, 32'h0,        5'd0,  0, 0};
      vt[1]  = '{1, 0, 0,  1, 1, 1, 1, 32'h0BAD0002, 5'd6,  0, 0, 0, 0, 32'h0,        5'd0,  0, 0};
      vt[2]  = '{0, 0, 0,  1, 1, 0, 0, 32'h12345678, 5'd3,  1, 1, 0, 0, 32'h12345678, 5'd3,  0, 0};
      vt[3]  = '{0, 0, 0,  1, 1, 1, 0, 32'hAAAA0001, 5'd9,  1, 1, 1, 0, 32'hAAAA0001, 5'd9,  0, 0};
      vt[4]  = '{0, 1, 0,  1, 0, 0, 1, 32'hBBBB0002, 5'd12, 1, 1, 1, 0, 32'hAAAA0001, 5'd9,  1, 0};
      vt[5]  = '{0, 1, 0,  1, 0, 0, 1, 32'hBBBB0002, 5'd12, 1, 1, 1, 0, 32'hAAAA0001, 5'd9,  2, 0};
      vt[6]  = '{0, 1, 0,  1, 0, 0, 1, 32'hBBBB0002, 5'd12, 1, 1, 1, 0, 32'hAAAA0001, 5'd9,  3, 0};
      vt[7]  = '{0, 0, 0,  1, 0, 0, 1, 32'hBBBB0002, 5'd12, 1, 0, 0, 1, 32'hBBBB0002, 5'd12, 3, 0};
      vt[8]  = '{1, 0, 0,  1, 1, 1, 1, 32'hCCCC0000, 5'd1,  0, 0, 0, 0, 32'h0,        5'd0,  0, 0};
      vt[9]  = '{0, 1, 1,  1, 0, 1, 0, 32'hCCCC0003, 5'd2,  0, 0, 0, 0, 32'h0,        5'd0,  1, 1};
      vt[10] = '{0, 0, 0,  0, 1, 0, 1, 32'hDDDD0004, 5'd7,  0, 0, 0, 0, 32'hDDDD0004, 5'd7,  1, 1};
      vt[11] = '{0, 0, 0,  1, 1, 0, 0, 32'hEEEE0005, 5'd1,  1, 1, 0, 0, 32'hEEEE0005, 5'd1,  1, 1};
      vt[12] = '{1, 1, 0,  1, 0, 1, 0, 32'hFFFF0006, 5'd2,  0, 0, 0, 0, 32'h0,        5'd0,  0, 0};
      vt[13] = '{0, 0, 0,  1, 0, 1, 0, 32'h77770007, 5'd8,  1, 0, 1, 0, 32'h77770007, 5'd8,  0, 0};

      for (int i = 0; i < 14; i++) begin
         clr   = vt[i].clr;
         stall = vt[i].stall;
         flush = vt[i].flush;
         din          = rand_st();
         din.valid    = vt[i].dvalid;
         din.ctl.wreg = vt[i].dwreg;
         din.ctl.wmem = vt[i].dwmem;
         din.ctl.beq  = vt[i].dbeq;
         din.a        = vt[i].da;
         din.rn       = vt[i].drn;
         step();
         chk($sformatf("v%0d evalid", i), 256'(e_if.valid),    256'(vt[i].xv));
         chk($sformatf("v%0d ewreg", i),  256'(e_if.ctl.wreg), 256'(vt[i].xw));
         chk($sformatf("v%0d ewmem", i),  256'(e_if.ctl.wmem), 256'(vt[i].xm));
         chk($sformatf("v%0d ebeq", i),   256'(e_if.ctl.beq),  256'(vt[i].xb));
         chk($sformatf("v%0d ea", i),     256'(e_if.a),        256'(vt[i].xa));
         chk($sformatf("v%0d ern", i),    256'(e_if.rn),       256'(vt[i].xr));
         chk($sformatf("v%0d stall_cnt", i),  256'(stall_cnt),  256'(vt[i].xsc));
         chk($sformatf("v%0d bubble_cnt", i), 256'(bubble_cnt), 256'(vt[i].xbc));
         if (vt[i].clr)
            chk($sformatf("v%0d all-zero", i), 256'(act), 256'(0));
      end

      // Saturation of a narrow bubble counter under a long flush.
      clr = 1'b1; stall = 1'b0; flush = 1'b0; din = rand_st();
      step();
      clr = 1'b0; flush = 1'b1;
      for (int i = 0; i < 20; i++) begin
         din = rand_st();
         step();
         chk($sformatf("sat bubble_cnt4 c%0d", i), 256'(bubble_cnt4),
             256'((i + 1 < 15) ? i + 1 : 15));
      end
      chk("sat bubble_cnt16", 256'(bubble_cnt), 256'(20));
      chk("sat evalid", 256'(e4_if.valid), 256'(0));
      flush = 1'b0; din = rand_st();
      step();
      chk("sat hold", 256'(bubble_cnt4), 256'(15));
      clr = 1'b1;
      step();
      chk("sat after clr", 256'(bubble_cnt4), 256'(0));

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         clr   = ($urandom_range(0, 39) == 0);
         flush = ($urandom_range(0, 4) == 0);
         stall = ($urandom_range(0, 2) == 0);
         din   = rand_st();
         step();
         chk($sformatf("rnd%0d e", i),          256'(act),         256'(m));
         chk($sformatf("rnd%0d e4", i),         256'(act4),        256'(m));
         chk($sformatf("rnd%0d stall_cnt", i),  256'(stall_cnt),   256'(msc));
         chk($sformatf("rnd%0d bubble_cnt", i), 256'(bubble_cnt),  256'(mbc));
         chk($sformatf("rnd%0d stall_cnt4", i), 256'(stall_cnt4),  256'(msc4));
         chk($sformatf("rnd%0d bubble_cnt4", i), 256'(bubble_cnt4), 256'(mbc4));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
